instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of PC and instruction-memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-004 SHALL have parameter BUF_DEPTH, default 2, number of entries in the fetch buffer (power of two, >=2).
REQ-005 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port imem_addr_o  output  ADDR_WIDTH  byte address presented to the combinational instruction memory.
REQ-008 SHALL have port imem_instr_i  input  DATA_WIDTH  instruction word returned combinationally for imem_addr_o in the same cycle.
REQ-009 SHALL have port redirect_i  input  1  one-cycle pulse: flush and restart fetch at redirect_pc_i.
REQ-010 SHALL have port redirect_pc_i  input  ADDR_WIDTH  new fetch address, sampled when redirect_i=1.
REQ-011 SHALL have port fetch_valid_o  output  1  head buffer entry valid toward decode.
REQ-012 SHALL have port fetch_ready_i  input  1  decode accepts head entry.
REQ-013 SHALL have port instr_o  output  DATA_WIDTH  instruction of head entry.
REQ-014 SHALL have port pc_o  output  ADDR_WIDTH  byte address of head entry.
REQ-015 SHALL have port misalign_err_o  output  1  sticky flag: a redirect to a non-word-aligned address was received.

Function
REQ-016 SHALL hold fetch PC register fpc; imem_addr_o = fpc at all times.
REQ-017 SHALL implement FSM states RUN and HALT; reset state RUN.
REQ-018 In RUN, without redirect, SHALL push {fpc, imem_instr_i} and set fpc <= fpc+4 when buffer not full or a pop occurs that cycle.
REQ-019 When the buffer is full and no pop occurs, SHALL neither push nor advance fpc.
REQ-020 fpc+4 SHALL wrap modulo 2^ADDR_WIDTH (all-ones-word-aligned +4 -> 0).
REQ-021 Pop SHALL occur when fetch_valid_o & fetch_ready_i; fetch_valid_o = buffer non-empty; instr_o/pc_o driven from head entry, stable while valid & !ready.
REQ-022 Fetch latency SHALL be one cycle: an entry pushed at edge N is visible on fetch_valid_o after edge N.
REQ-023 On redirect_i=1 with redirect_pc_i[1:0]=00: buffer emptied, fpc <= redirect_pc_i, no push that cycle, state <= RUN (also from HALT).
REQ-024 On redirect_i=1 with redirect_pc_i[1:0]!=00: buffer emptied, fpc unchanged, misalign_err_o <= 1, state <= HALT.
REQ-025 In HALT, SHALL not push; fetch_valid_o = 0; only an aligned redirect leaves HALT.
REQ-026 Redirect SHALL have priority over push; a handshake completing in the redirect cycle counts as consumed, then flush applies.
REQ-027 misalign_err_o SHALL clear only on reset.
REQ-028 Buffer pointers SHALL wrap at BUF_DEPTH; simultaneous push and pop on full or empty buffer SHALL keep occupancy consistent (push+pop on empty is legal: entry enqueued, not bypassed).

Reset
REQ-029 rst_ni=0 SHALL immediately (asynchronously) set fpc=RESET_PC, buffer empty, state=RUN, fetch_valid_o=0, misalign_err_o=0; instr_o/pc_o values irrelevant while invalid.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; first push after release is at RESET_PC on the first rising edge with rst_ni=1.

Verification
REQ-031 Reset release, ready=1, ROM word[i]=i -> pc_o 0,4,8,... on consecutive cycles, instr_o 0,1,2, valid from cycle 1 onward.
REQ-032 ready=0 for 5 cycles after reset -> exactly 2 entries (PC 0,4) buffered, imem_addr_o held at 8; ready=1 -> PC 0,4,8 delivered in order, no gap or duplicate.
REQ-033 Redirect to 0x40 while buffer holds PC 8,12 -> 8/12 never presented after the redirect cycle; next valid entry pc_o=0x40 one cycle later.
REQ-034 Redirect to 0x42 -> misalign_err_o=1, valid=0, fetch stalls; later redirect to 0x80 -> RUN resumes at 0x80, misalign_err_o stays 1.
REQ-035 Redirect to 0xFFFF_FFFC, ready=1 -> pc_o 0xFFFF_FFFC then 0x0000_0000.
REQ-036 rst_ni pulsed low asynchronously between edges with full buffer -> valid drops immediately; after release pc_o sequence restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a fetch PC drives a combinational instruction memory and
// fills a small FIFO that decode drains through a valid/ready handshake.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  misalign_err_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] buf_pc_q    [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_instr_q [BUF_DEPTH];

  logic full, pop, push, aligned;

  assign full    = (count_q == CNT_W'(BUF_DEPTH));
  assign pop     = fetch_valid_o & fetch_ready_i;
  // A pop in the same cycle frees a slot, so a full buffer can still accept a push.
  assign push    = (state_q == RUN) & ~redirect_i & (~full | pop);
  assign aligned = (redirect_pc_i[1:0] == 2'b00);

  assign imem_addr_o    = fpc_q;
  assign fetch_valid_o  = (count_q != '0);
  assign instr_o        = buf_instr_q[rd_ptr_q];
  assign pc_o           = buf_pc_q[rd_ptr_q];
  assign misalign_err_o = err_q;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (aligned) begin
        fpc_d   = redirect_pc_i;
        state_d = RUN;
      end else begin
        err_d   = 1'b1;
        state_d = HALT;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        fpc_d    = fpc_q + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= fpc_q;
      buf_instr_q[wr_ptr_q] <= imem_instr_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: the ROM returns word index (addr>>2) as the instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        misalign_err;

  int n_vec  = 0;
  int n_fail = 0;

  instr_fetch dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .imem_addr_o    (imem_addr),
    .imem_instr_i   (imem_instr),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .fetch_valid_o  (fetch_valid),
    .fetch_ready_i  (fetch_ready),
    .instr_o        (instr),
    .pc_o           (pc),
    .misalign_err_o (misalign_err)
  );

  always #5 clk = ~clk;

  assign imem_instr = imem_addr >> 2;

  typedef struct {
    logic        rst_n;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic v, input logic [31:0] p, input logic [31:0] ins,
                     input logic [31:0] a, input logic e);
    vec_t t;
    t = '{rst_n: r, redirect: rd, rpc: rpc, ready: rdy, valid: v, pc: p, instr: ins,
          addr: a, err: e};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t t);
    check("valid", idx, 32'(fetch_valid), 32'(t.valid));
    check("imem_addr", idx, imem_addr, t.addr);
    check("misalign_err", idx, 32'(misalign_err), 32'(t.err));
    if (t.valid) begin
      check("pc", idx, pc, t.pc);
      check("instr", idx, instr, t.instr);
    end
  endtask

  initial begin
    // rst redir rpc          rdy  valid pc           instr        addr         err
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'h0,        0); // 0 reset state
    add(1, 0, 32'h0,        1,   1, 32'h0,        32'h0,        32'h4,        0); // 1 first entry
    add(1, 0, 32'h0,        1,   1, 32'h4,        32'h1,        32'h8,        0); // 2
    add(1, 0, 32'h0,        0,   1, 32'h8,        32'h2,        32'hC,        0); // 3 stall, fill
    add(1, 1, 32'h40,       0,   1, 32'h8,        32'h2,        32'h10,       0); // 4 redirect, full
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'h40,       0); // 5 flushed
    add(1, 0, 32'h0,        1,   1, 32'h40,       32'h10,       32'h44,       0); // 6
    add(1, 1, 32'h42,       1,   1, 32'h44,       32'h11,       32'h48,       0); // 7 misaligned
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'h48,       1); // 8 halted
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'h48,       1); // 9
    add(1, 1, 32'h80,       1,   0, 32'h0,        32'h0,        32'h48,       1); // 10 leave halt
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'h80,       1); // 11
    add(1, 0, 32'h0,        1,   1, 32'h80,       32'h20,       32'h84,       1); // 12
    add(1, 1, 32'hFFFF_FFFC, 1,  1, 32'h84,       32'h21,       32'h88,       1); // 13 top of space
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        32'hFFFF_FFFC, 1); // 14
    add(1, 0, 32'h0,        1,   1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0,      1); // 15 wrap
    add(1, 0, 32'h0,        1,   1, 32'h0,        32'h0,        32'h4,        1); // 16
    add(1, 0, 32'h0,        0,   1, 32'h4,        32'h1,        32'h8,        1); // 17 fill
    add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        32'h0,        0); // 18 async reset
    add(1, 0, 32'h0,        0,   0, 32'h0,        32'h0,        32'h0,        0); // 19 release
    add(1, 0, 32'h0,        0,   1, 32'h0,        32'h0,        32'h4,        0); // 20
    add(1, 0, 32'h0,        0,   1, 32'h0,        32'h0,        32'h8,        0); // 21 full, held
    add(1, 0, 32'h0,        0,   1, 32'h0,        32'h0,        32'h8,        0); // 22
    add(1, 0, 32'h0,        0,   1, 32'h0,        32'h0,        32'h8,        0); // 23
    add(1, 0, 32'h0,        1,   1, 32'h0,        32'h0,        32'h8,        0); // 24 drain
    add(1, 0, 32'h0,        1,   1, 32'h4,        32'h1,        32'hC,        0); // 25
    add(1, 0, 32'h0,        1,   1, 32'h8,        32'h2,        32'h10,       0); // 26

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n       = vecs[i].rst_n;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      fetch_ready = vecs[i].ready;
      #1;
      n_vec++;
      check_outputs(i, vecs[i]);
    end

    // Fill the buffer, then pulse reset strictly between two rising edges.
    @(negedge clk);
    redirect    = 1'b0;
    fetch_ready = 1'b0;
    #1;
    n_vec++;
    check("pre-pulse valid", n_vec, 32'(fetch_valid), 32'h1);
    check("pre-pulse pc", n_vec, pc, 32'hC);
    @(negedge clk);
    #1;
    check("full pc held", n_vec, pc, 32'hC);
    check("full addr held", n_vec, imem_addr, 32'h14);
    rst_n = 1'b0;
    #1;
    n_vec++;
    check("pulse valid", n_vec, 32'(fetch_valid), 32'h0);
    check("pulse addr", n_vec, imem_addr, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b1;
    #1;
    n_vec++;
    check("restart valid", n_vec, 32'(fetch_valid), 32'h1);
    check("restart pc", n_vec, pc, 32'h0);
    check("restart addr", n_vec, imem_addr, 32'h4);
    @(negedge clk);
    #1;
    n_vec++;
    check("restart pc+4", n_vec, pc, 32'h4);
    check("restart instr", n_vec, instr, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
